jm_kernel_adapter: RTL
======================

# jm_kernel_adapter

Per-kernel adapter directly downstream of the job scheduler, one instance per kernel slot. It accepts one job descriptor on the scheduler's `engine_start`/`engine_data` strobe and drives an HLS `ap_ctrl_hs` kernel with it. It then captures the kernel's return value, or a timeout code, and presents a RETURN_WIDTH completion word back to the scheduler on the `complete_ready`/`complete_accept` handshake. It also counts kernel run cycles for debug readout.

## Interface
- HOST_DWIDTH, 1024: descriptor width.
- PASID_WIDTH, 9: process ID width.
- RETURN_WIDTH, 41: completion word width; must equal PASID_WIDTH+32.
- ARG_WIDTH, 960: kernel argument width, taken from descriptor bits [1023:64].
- TIMEOUT_CYCLES, 2^24: run-cycle limit. 0 disables the timeout.
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- engine_start  in  1  single-cycle descriptor strobe from the scheduler.
- engine_data  in  HOST_DWIDTH  descriptor; valid only with `engine_start`.
- engine_ready  out  1  adapter idle and able to take a job.
- complete_ready  out  1  completion word valid.
- complete_accept  in  1  single-cycle consume strobe from the scheduler.
- complete_data  out  RETURN_WIDTH  {pasid, return_code}.
- ap_start  out  1  kernel start.
- ap_ready  in  1  kernel has taken its arguments.
- ap_done  in  1  kernel finished; single-cycle pulse.
- ap_return  in  32  kernel return value; valid with `ap_done`.
- kernel_args  out  ARG_WIDTH  latched descriptor arguments.
- run_cycles  out  32  cycle count of the last job; saturating.
- timeout_cnt  out  16  number of timeouts since reset; saturating.

## Operation
- **Descriptor layout:** [PASID_WIDTH-1:0] pasid, [63:PASID_WIDTH] reserved (ignored), [1023:64] kernel_args.
- **IDLE**
  - `engine_ready`=1.
  - On `engine_start`: latch pasid and kernel_args, clear the run counter, go to START.
  - `engine_start` while `engine_ready`=0 is a protocol error: ignored, no state change.
- **START**
  - `ap_start`=1, held until `ap_ready`=1.
  - Same cycle as `ap_ready`: drop `ap_start`, go to RUN.
  - If `ap_done` arrives in the same cycle as `ap_ready`: capture `ap_return` and go straight to DONE.
- **RUN**
  - The run counter increments every cycle.
  - On `ap_done`: capture `ap_return`, go to DONE.
  - If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 without `ap_done`: set return_code=RC_TIMEOUT (32'hFFFF_0001), increment `timeout_cnt`, go to DRAIN.
- **DRAIN**
  - The completion is presented immediately (`complete_ready`=1).
  - The adapter still waits for the late `ap_done`; that `ap_return` is discarded.
  - Return to IDLE only when both the late `ap_done` and `complete_accept` have been seen, in either order or the same cycle.
- **DONE**
  - `complete_ready`=1.
  - On `complete_accept`: go to IDLE.
- **Completion word:** `complete_data`={pasid, return_code}. It is held stable while `complete_ready`=1. `complete_accept` while `complete_ready`=0 is ignored.
- **run_cycles:** updated on leaving RUN. Saturates at 32'hFFFF_FFFF. `timeout_cnt` saturates at 16'hFFFF.

## Timing
- **Reset values:**
  - state=IDLE.
  - `engine_ready`=1.
  - `ap_start`=0, `complete_ready`=0.
  - `complete_data`=0, `kernel_args`=0.
  - `run_cycles`=0, `timeout_cnt`=0.
- **Start path:** `engine_start` at cycle T gives `engine_ready`=0 and `ap_start`=1 at T+1. `kernel_args` is valid from T+1.
- **Done path:** `ap_done` at cycle D gives `complete_ready`=1 at D+1.
- **Accept path:** `complete_accept` at cycle A gives `complete_ready`=0 and `engine_ready`=1 at A+1. The earliest next `engine_start` is accepted at A+1.
- **Latency:** minimum start-to-completion is 2 cycles (`ap_ready` and `ap_done` at T+1).
- **Registered outputs:** all outputs are registered; there is no combinational path from inputs to outputs.
- **Reset mid-job:** returns to IDLE next cycle. Any pending completion is lost. `ap_start` deasserts.

## Structure
- Shared package `jm_pkg` holds:
  - state enum (IDLE, START, RUN, DRAIN, DONE);
  - descriptor field offsets (PASID_LSB=0, ARG_LSB=64);
  - RC_TIMEOUT;
  - the RETURN_WIDTH = PASID_WIDTH+32 relation.
- Single module, no sub-modules; the counter and FSM are inline.

## Test plan
- **Basic job:** `engine_data` pasid=9'h05; kernel returns `ap_ready` at T+2 and `ap_done` with `ap_return`=32'h0000_00AB at T+10 → `complete_data`={9'h05, 32'h0000_00AB} at T+11 and `run_cycles`=8; accept → `engine_ready` back at the next cycle.
- **Fast kernel:** `ap_ready` and `ap_done` both at T+1 → `complete_ready` at T+2 and `run_cycles`=0.
- **Timeout:** TIMEOUT_CYCLES=16 with no `ap_done` → `complete_data` low 32 bits=32'hFFFF_0001 and `timeout_cnt`=1. Then accept, then a late `ap_done` → `engine_ready`=1 only after the late `ap_done`. Also repeat with the late `ap_done` arriving before the accept.
- **Backpressure:** withhold `complete_accept` for 50 cycles → `complete_data` stable, `engine_ready`=0; a stray `engine_start` during this window is ignored.
- **Reset mid-RUN:** assert `reset` during RUN → next cycle `ap_start`=0, `complete_ready`=0, `engine_ready`=1; a new job then completes normally.
- **Back-to-back jobs:** two jobs (pasid 1 then 2), the second `engine_start` at A+1 → two completions in order with the correct pasid fields.

Source files
------------

// File: rtl/jm_pkg.sv
// Shared definitions for the job-scheduler kernel adapters: FSM states,
// descriptor field offsets and completion codes.
package jm_pkg;

    // Adapter life cycle for one job
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Descriptor field offsets
    localparam int unsigned PASID_LSB = 0;
    localparam int unsigned ARG_LSB   = 64;

    // Completion word = {pasid, return_code}
    localparam int unsigned RC_WIDTH   = 32;
    localparam logic [RC_WIDTH-1:0] RC_TIMEOUT = 32'hFFFF_0001;

    // Width of the completion word for a given PASID width
    function automatic int unsigned return_width(input int unsigned pasid_width);
        return pasid_width + RC_WIDTH;
    endfunction

endpackage : jm_pkg

// File: rtl/jm_kernel_adapter.sv
// Per-kernel adapter: takes one descriptor from the scheduler, runs an
// ap_ctrl_hs kernel with it, and hands back {pasid, return_code}.
module jm_kernel_adapter
    import jm_pkg::*;
#(
    parameter int unsigned HOST_DWIDTH    = 1024,
    parameter int unsigned PASID_WIDTH    = 9,
    parameter int unsigned RETURN_WIDTH   = 41,
    parameter int unsigned ARG_WIDTH      = 960,
    parameter int unsigned TIMEOUT_CYCLES = 32'd16777216
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    engine_start,
    input  logic [HOST_DWIDTH-1:0]  engine_data,
    output logic                    engine_ready,
    output logic                    complete_ready,
    input  logic                    complete_accept,
    output logic [RETURN_WIDTH-1:0] complete_data,
    output logic                    ap_start,
    input  logic                    ap_ready,
    input  logic                    ap_done,
    input  logic [31:0]             ap_return,
    output logic [ARG_WIDTH-1:0]    kernel_args,
    output logic [31:0]             run_cycles,
    output logic [15:0]             timeout_cnt
);

    if (RETURN_WIDTH != return_width(PASID_WIDTH)) begin : g_bad_return_width
        $error("RETURN_WIDTH must equal PASID_WIDTH + 32");
    end

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [PASID_WIDTH-1:0] pasid_q, pasid_d;
    logic [RC_WIDTH-1:0]    rc_q, rc_d;
    logic [ARG_WIDTH-1:0]   args_q, args_d;
    logic [31:0]            cnt_q, cnt_d;
    logic [31:0]            run_cycles_q, run_cycles_d;
    logic [15:0]            timeout_cnt_q, timeout_cnt_d;
    logic                   done_seen_q, done_seen_d;
    logic                   acc_seen_q, acc_seen_d;
    logic                   engine_ready_q, engine_ready_d;
    logic                   ap_start_q, ap_start_d;
    logic                   complete_ready_q, complete_ready_d;

    logic [31:0] cnt_inc;
    logic        timeout_hit;
    logic        drain_done, drain_acc;

    // Reserved descriptor bits carry no meaning for the kernel
    logic unused_reserved;
    assign unused_reserved = ^engine_data[ARG_LSB-1:PASID_LSB+PASID_WIDTH];

    // Next-state, datapath capture and registered-output decode
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d        = state_q;
        pasid_d        = pasid_q;
        rc_d           = rc_q;
        args_d         = args_q;
        cnt_d          = cnt_q;
        run_cycles_d   = run_cycles_q;
        timeout_cnt_d  = timeout_cnt_q;
        done_seen_d    = done_seen_q;
        acc_seen_d     = acc_seen_q;

        cnt_inc     = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_LAST);
        drain_done  = done_seen_q | ap_done;
        drain_acc   = acc_seen_q | (complete_accept & complete_ready_q);

        unique case (state_q)
            IDLE: begin
                if (engine_start) begin
                    pasid_d = engine_data[PASID_LSB +: PASID_WIDTH];
                    args_d  = engine_data[ARG_LSB +: ARG_WIDTH];
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (ap_ready) begin
                    if (ap_done) begin
                        // Kernel finished in its acceptance cycle: it never ran
                        rc_d         = ap_return;
                        run_cycles_d = '0;
                        state_d      = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_inc;
                if (ap_done) begin
                    rc_d         = ap_return;
                    run_cycles_d = cnt_inc;
                    state_d      = DONE;
                end else if (timeout_hit) begin
                    rc_d          = RC_TIMEOUT;
                    run_cycles_d  = cnt_inc;
                    timeout_cnt_d = (timeout_cnt_q == 16'hFFFF) ? timeout_cnt_q
                                                                : timeout_cnt_q + 16'd1;
                    done_seen_d   = 1'b0;
                    acc_seen_d    = 1'b0;
                    state_d       = DRAIN;
                end
            end
            DRAIN: begin
                // The late ap_done must be absorbed before the kernel is reused
                if (drain_done && drain_acc) begin
                    state_d = IDLE;
                end else begin
                    done_seen_d = drain_done;
                    acc_seen_d  = drain_acc;
                end
            end
            DONE: begin
                if (complete_accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they register cleanly
        engine_ready_d   = (state_d == IDLE);
        ap_start_d       = (state_d == START);
        complete_ready_d = (state_d == DONE) || ((state_d == DRAIN) && !acc_seen_d);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            // NOTE: the wide argument/completion registers are reset because their reset value is visible on ports.
            state_q          <= IDLE;
            pasid_q          <= '0;
            rc_q             <= '0;
            args_q           <= '0;
            cnt_q            <= '0;
            run_cycles_q     <= '0;
            timeout_cnt_q    <= '0;
            done_seen_q      <= 1'b0;
            acc_seen_q       <= 1'b0;
            engine_ready_q   <= 1'b1;
            ap_start_q       <= 1'b0;
            complete_ready_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            pasid_q          <= pasid_d;
            rc_q             <= rc_d;
            args_q           <= args_d;
            cnt_q            <= cnt_d;
            run_cycles_q     <= run_cycles_d;
            timeout_cnt_q    <= timeout_cnt_d;
            done_seen_q      <= done_seen_d;
            acc_seen_q       <= acc_seen_d;
            engine_ready_q   <= engine_ready_d;
            ap_start_q       <= ap_start_d;
            complete_ready_q <= complete_ready_d;
        end
    end

    assign engine_ready   = engine_ready_q;
    assign ap_start       = ap_start_q;
    assign complete_ready = complete_ready_q;
    assign complete_data  = {pasid_q, rc_q};
    assign kernel_args    = args_q;
    assign run_cycles     = run_cycles_q;
    assign timeout_cnt    = timeout_cnt_q;

endmodule : jm_kernel_adapter
